// File: rtl/dcache_pkg.sv
// Shared types for the dcache writeback buffer: FSM state and entry layout.
package dcache_pkg;

    localparam int WB_XLEN = 32;
    localparam int WB_BLK  = 128;

    typedef enum logic [0:0] {
        WB_REQ  = 1'b0,
        WB_WAIT = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic [WB_XLEN-1:0] addr;
        logic [WB_BLK-1:0]  data;
    } wb_entry_t;

endpackage

// File: rtl/dcache_wb_fifo.sv
// Circular entry storage for the writeback buffer; exposes head,
// per-entry valid bits and the raw entry array for hazard lookup.
module dcache_wb_fifo
    import dcache_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  wb_entry_t        push_entry_i,
    input  logic             pop_i,
    output wb_entry_t        head_o,
    output logic [DEPTH-1:0] valid_o,
    output wb_entry_t        entries_o [DEPTH],
    output logic [PW-1:0]    rptr_o,
    output logic [PW:0]      count_o
);

    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [PW:0]      count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    wb_entry_t        entry_q [DEPTH];
    wb_entry_t        entry_d [DEPTH];

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        valid_d = valid_q;
        entry_d = entry_q;
        if (push_i) begin
            entry_d[wptr_q] = push_entry_i;
            valid_d[wptr_q] = 1'b1;
            wptr_d          = wptr_q + 1'b1;
        end
        if (pop_i) begin
            valid_d[rptr_q] = 1'b0;
            rptr_d          = rptr_q + 1'b1;
        end
        if (push_i && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (pop_i && !push_i) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Line data is only observed through valid bits, so no reset.
    always_ff @(posedge clk_i) begin
        entry_q <= entry_d;
    end

    assign head_o    = entry_q[rptr_q];
    assign valid_o   = valid_q;
    assign entries_o = entry_q;
    assign rptr_o    = rptr_q;
    assign count_o   = count_q;

endmodule

// File: rtl/dcache_wb_buffer.sv
// Dcache writeback buffer: queues evicted lines, drains them one at a time.
// Define DCACHE_WB_FWD_EN to forward buffered data on lookup hits.
module dcache_wb_buffer
    import dcache_pkg::*;
#(
    parameter int XLEN     = WB_XLEN,
    parameter int BLK_SIZE = WB_BLK,
    parameter int BOFFSET  = 4,
    parameter int DEPTH    = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                wb_valid_i,
    output logic                wb_ready_o,
    input  logic [XLEN-1:0]     wb_addr_i,
    input  logic [BLK_SIZE-1:0] wb_data_i,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [XLEN-1:0]     mem_req_addr_o,
    output logic [BLK_SIZE-1:0] mem_req_data_o,
    input  logic                mem_res_valid_i,
    input  logic [XLEN-1:0]     lkp_addr_i,
    output logic                lkp_hit_o,
    output logic [BLK_SIZE-1:0] lkp_data_o,
    output logic                empty_o,
    output logic                full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [XLEN-1:0] BLK_MASK =
        ~((XLEN'(1) << BOFFSET) - XLEN'(1));

    wb_state_e        state_q, state_d;
    logic             push, pop;
    wb_entry_t        push_entry, head;
    logic [DEPTH-1:0] valid;
    wb_entry_t        entries [DEPTH];
    logic [PW-1:0]    rptr, scan_idx;
    logic [PW:0]      count;
    logic             lkp_hit;
    logic [BLK_SIZE-1:0] lkp_data;

    assign empty_o    = (count == '0);
    assign full_o     = (count == (PW+1)'(DEPTH));
    assign wb_ready_o = !full_o;
    assign push       = wb_valid_i && wb_ready_o;
    assign pop        = (state_q == WB_WAIT) && mem_res_valid_i;
    assign push_entry = '{addr: wb_addr_i, data: wb_data_i};

    dcache_wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (push),
        .push_entry_i(push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .valid_o     (valid),
        .entries_o   (entries),
        .rptr_o      (rptr),
        .count_o     (count)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WB_REQ:  if (mem_req_valid_o && mem_req_ready_i) state_d = WB_WAIT;
            WB_WAIT: if (mem_res_valid_i) state_d = WB_REQ;
            default: state_d = WB_REQ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= WB_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    assign mem_req_valid_o = (state_q == WB_REQ) && !empty_o;
    assign mem_req_addr_o  = head.addr;
    assign mem_req_data_o  = head.data;

    // Scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        lkp_hit  = 1'b0;
        lkp_data = '0;
        scan_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = rptr + PW'(k);
            if (valid[scan_idx] &&
                (((entries[scan_idx].addr ^ lkp_addr_i) & BLK_MASK) == '0)) begin
                lkp_hit  = 1'b1;
                lkp_data = entries[scan_idx].data;
            end
        end
    end

    assign lkp_hit_o = lkp_hit;
`ifdef DCACHE_WB_FWD_EN
    assign lkp_data_o = lkp_data;
`else
    assign lkp_data_o = '0;
`endif

endmodule
